// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage access unit: mem_signals layout, size codes,
// FSM encoding and the registered memory command payload.
package mips_mem_pkg;

  localparam int unsigned MEM_DW  = 32;
  localparam int unsigned MEM_BE  = 4;
  localparam int unsigned NB_SIZE = 3;

  localparam int unsigned SIG_SIGN  = 5;
  localparam int unsigned SIG_READ  = 4;
  localparam int unsigned SIG_WRITE = 3;

  localparam logic [NB_SIZE-1:0] SIZE_WORD = 3'b100;
  localparam logic [NB_SIZE-1:0] SIZE_HALF = 3'b010;
  localparam logic [NB_SIZE-1:0] SIZE_BYTE = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [MEM_DW-1:0] addr;
    logic [MEM_BE-1:0] be;
    logic [MEM_DW-1:0] wdata;
  } mem_cmd_t;

  function automatic logic size_legal(input logic [NB_SIZE-1:0] size);
    return (size == SIZE_WORD) || (size == SIZE_HALF) || (size == SIZE_BYTE);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane logic: store byte enables and data replication, load extraction and
// extension, and alignment check for a given size and low address bits.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [NB_SIZE-1:0] size,
  input  logic [1:0]         addr_lo,
  input  logic               sign,
  input  logic [MEM_DW-1:0]  wdata,
  input  logic [MEM_DW-1:0]  rdata,
  output logic [MEM_BE-1:0]  be,
  output logic [MEM_DW-1:0]  wdata_rep,
  output logic [MEM_DW-1:0]  load_ext,
  output logic               misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
    half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    be         = '0;
    wdata_rep  = wdata;
    load_ext   = rdata;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        load_ext  = {{24{sign & byte_sel[7]}}, byte_sel};
      end
      SIZE_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        load_ext   = {{16{sign & half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      SIZE_WORD: begin
        be         = 4'b1111;
        misaligned = |addr_lo;
      end
      default: be = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: validates the decoded access, drives a req/ack data-memory
// port, extends load data and stalls the pipeline until the access completes.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned NB_DATA   = 32,
  parameter int unsigned NB_MEMSIG = 6,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 op_valid,
  input  logic [NB_MEMSIG-1:0] mem_signals,
  input  logic [NB_DATA-1:0]   op_addr,
  input  logic [NB_DATA-1:0]   op_wdata,
  output logic                 stall,
  output logic                 done,
  output logic                 error,
  output logic [NB_DATA-1:0]   load_data,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [NB_DATA-1:0]   mem_addr,
  output logic [3:0]           mem_be,
  output logic [NB_DATA-1:0]   mem_wdata,
  input  logic                 mem_ack,
  input  logic [NB_DATA-1:0]   mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit          TO_EN = (TIMEOUT != 0);

  state_t             state_q, state_d;
  mem_cmd_t           cmd_q, cmd_d;
  logic               req_q, req_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [MEM_DW-1:0]  load_q, load_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  // Access context kept for load extraction while the request is outstanding
  logic [NB_SIZE-1:0] size_q, size_d;
  logic [1:0]         lane_q, lane_d;
  logic               sign_q, sign_d;
  logic               read_q, read_d;

  logic               is_read, is_write, access, illegal;
  logic [NB_SIZE-1:0] al_size;
  logic [1:0]         al_lane;
  logic [MEM_BE-1:0]  al_be;
  logic [MEM_DW-1:0]  al_wdata, al_load;
  logic               al_misaligned;

  assign is_read  = mem_signals[SIG_READ];
  assign is_write = mem_signals[SIG_WRITE];
  assign access   = op_valid & (is_read | is_write);
  assign illegal  = (is_read & is_write) | ~size_legal(mem_signals[NB_SIZE-1:0]);
  assign stall    = ((state_q == ST_IDLE) & access) | (state_q == ST_REQ);

  // Lane logic sees the incoming op in IDLE and the held context during REQ
  assign al_size = (state_q == ST_IDLE) ? mem_signals[NB_SIZE-1:0] : size_q;
  assign al_lane = (state_q == ST_IDLE) ? op_addr[1:0] : lane_q;

  mem_lane_align u_align (
    .size       (al_size),
    .addr_lo    (al_lane),
    .sign       (sign_q),
    .wdata      (op_wdata),
    .rdata      (mem_rdata),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .load_ext   (al_load),
    .misaligned (al_misaligned)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    req_d   = req_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load_d  = load_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    lane_d  = lane_q;
    sign_d  = sign_q;
    read_d  = read_q;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (illegal | al_misaligned) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            cmd_d.we    = is_write;
            cmd_d.addr  = {op_addr[NB_DATA-1:2], 2'b00};
            cmd_d.be    = al_be;
            cmd_d.wdata = al_wdata;
            req_d       = 1'b1;
            cnt_d       = '0;
            size_d      = mem_signals[NB_SIZE-1:0];
            lane_d      = op_addr[1:0];
            sign_d      = mem_signals[SIG_SIGN];
            read_d      = is_read;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // An ack in the timeout cycle still counts as success
        if (mem_ack) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
          if (read_q) load_d = al_load;
        end else if (TO_EN && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          load_d  = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      lane_q  <= '0;
      sign_q  <= 1'b0;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      sign_q  <= sign_d;
      read_q  <= read_d;
    end
  end

  assign done      = done_q;
  assign error     = err_q;
  assign load_data = load_q;
  assign mem_req   = req_q;
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_be    = cmd_q.be;
  assign mem_wdata = cmd_q.wdata;

endmodule
